// File: rtl/scdaq_pkg.sv
// Shared constants for the scdaq readout scheduler: FSM state encoding,
// default data-path sizes and the Ack-timeout counter width helper.
package scdaq_pkg;

  // FSM state encoding (kept as plain constants for legacy tool flows)
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SCAN     = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK = 3'd3;
  localparam logic [2:0] ST_FETCH    = 3'd4;
  localparam logic [2:0] ST_PUSH     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
  localparam logic [2:0] ST_RELEASE  = 3'd7;

  // Default data-path sizes
  localparam int DEF_PRECISION    = 14;
  localparam int DEF_NSAMPLES     = 512;
  localparam int DEF_RDO_ADD_BLEN = 9;

  // Width needed to count up to 'limit' inclusive (at least 1 bit)
  function automatic int tmo_cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/scdaq_rdo_mux.sv
// Combinational NCH-to-1 selector of one PRECISION-wide slice of the
// concatenated channel data bus. Channel k lives at [k*PRECISION +: PRECISION].
module scdaq_rdo_mux
  import scdaq_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CH_BLEN   = 2,
  parameter int PRECISION = DEF_PRECISION
) (
  input  logic [NCH*PRECISION-1:0] q,
  input  logic [CH_BLEN-1:0]       sel,
  output logic [PRECISION-1:0]     data
);

  logic [PRECISION-1:0] slice [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign slice[gi] = q[gi*PRECISION +: PRECISION];
  end

  // Pick the slice of the channel currently being served
  always_comb begin
    data = slice[sel];
  end

endmodule

// File: rtl/scdaq_rdo_sched.sv
// Readout scheduler: on Start, visits each enabled channel in ascending
// order, runs the Req/Ack/Done handshake, sweeps the readout address over
// all samples and forwards each sample as a tagged valid/ready stream word.
// Optional build macro SCDAQ_RDO_TIMEOUT_EN adds an Ack timeout with sticky
// per-channel Timeout_Err flags; without it WAIT_ACK waits indefinitely.
module scdaq_rdo_sched
  import scdaq_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int CH_BLEN      = 2,
  parameter int NSAMPLES     = DEF_NSAMPLES,
  parameter int PRECISION    = DEF_PRECISION,
  parameter int RDO_ADD_BLEN = DEF_RDO_ADD_BLEN,
  parameter int RD_LAT       = 1,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic                      RDO_Clock,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [NCH-1:0]            CH_EN,
  output logic                      Busy,
  output logic                      Round_Done,
  output logic [NCH-1:0]            RDO_Req,
  input  logic [NCH-1:0]            RDO_Ack,
  output logic [RDO_ADD_BLEN-1:0]   RDO_Add,
  input  logic [NCH*PRECISION-1:0]  RDO_Q,
  output logic [NCH-1:0]            RDO_Done,
  output logic                      OUT_Valid,
  input  logic                      OUT_Ready,
  output logic [PRECISION-1:0]      OUT_Data,
  output logic [CH_BLEN-1:0]        OUT_Ch,
  output logic                      OUT_Last,
  output logic [NCH-1:0]            Timeout_Err
);

  // Pointer is one bit wider than a channel index so it can reach NCH,
  // which is how SCAN knows the round is over.
  localparam int PTR_W = CH_BLEN + 1;
  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  // Reject unsupported read latencies / timeout limits at elaboration
  if (RD_LAT < 1 || RD_LAT > 3 || ACK_TIMEOUT < 1) begin : g_cfg_check
    $error("scdaq_rdo_sched: RD_LAT must be 1..3 and ACK_TIMEOUT >= 1");
  end

  logic [2:0]              state_reg, state_next;
  logic [NCH-1:0]          snap_reg, snap_next;
  logic [PTR_W-1:0]        ptr_reg, ptr_next;
  logic [RDO_ADD_BLEN-1:0] add_reg, add_next;
  logic [LAT_W-1:0]        cnt_reg, cnt_next;
  logic                    out_valid_reg, out_valid_next;
  logic [PRECISION-1:0]    out_data_reg, out_data_next;
  logic [CH_BLEN-1:0]      out_ch_reg, out_ch_next;
  logic                    out_last_reg, out_last_next;

  logic [CH_BLEN-1:0]      ch_idx;
  logic                    ptr_in_range;
  logic [NCH-1:0]          ch_onehot;
  logic                    ack_sel;
  logic                    snap_sel;
  logic                    last_sample;
  logic [PRECISION-1:0]    mux_data;

  assign ch_idx       = ptr_reg[CH_BLEN-1:0];
  assign ptr_in_range = (ptr_reg < PTR_W'(NCH));
  assign ch_onehot    = NCH'(1) << ch_idx;
  assign ack_sel      = RDO_Ack[ch_idx];
  assign snap_sel     = snap_reg[ch_idx];
  assign last_sample  = (add_reg == RDO_ADD_BLEN'(NSAMPLES - 1));

  scdaq_rdo_mux #(
    .NCH       (NCH),
    .CH_BLEN   (CH_BLEN),
    .PRECISION (PRECISION)
  ) u_mux (
    .q    (RDO_Q),
    .sel  (ch_idx),
    .data (mux_data)
  );

`ifdef SCDAQ_RDO_TIMEOUT_EN
  localparam int TMO_W = tmo_cnt_width(ACK_TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [NCH-1:0]   tmo_err_reg, tmo_err_next;
  assign Timeout_Err = tmo_err_reg;
`else
  assign Timeout_Err = '0;
`endif

  // Handshake outputs are decoded from state so they drop the very cycle
  // the FSM leaves the owning states (including on Reset).
  assign Busy       = (state_reg != ST_IDLE);
  assign Round_Done = (state_reg == ST_SCAN) && !ptr_in_range;
  assign RDO_Req    = (state_reg == ST_REQ || state_reg == ST_WAIT_ACK ||
                       state_reg == ST_FETCH || state_reg == ST_PUSH) ? ch_onehot : '0;
  assign RDO_Done   = (state_reg == ST_DONE) ? ch_onehot : '0;
  assign RDO_Add    = add_reg;
  assign OUT_Valid  = out_valid_reg;
  assign OUT_Data   = out_data_reg;
  assign OUT_Ch     = out_ch_reg;
  assign OUT_Last   = out_last_reg;

  // Next-state and data-path update for the round/channel/sample sequencing
  always_comb begin
    state_next     = state_reg;
    snap_next      = snap_reg;
    ptr_next       = ptr_reg;
    add_next       = add_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_last_next  = out_last_reg;
`ifdef SCDAQ_RDO_TIMEOUT_EN
    tmo_cnt_next   = tmo_cnt_reg;
    tmo_err_next   = tmo_err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (Start) begin
          snap_next  = CH_EN;
          ptr_next   = '0;
          state_next = ST_SCAN;
`ifdef SCDAQ_RDO_TIMEOUT_EN
          tmo_err_next = '0;
`endif
        end
      end
      ST_SCAN: begin
        if (!ptr_in_range) begin
          state_next = ST_IDLE;
        end else if (!snap_sel) begin
          ptr_next = ptr_reg + PTR_W'(1);
        end else begin
          add_next   = '0;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is deliberately not looked at here; it is sampled in WAIT_ACK
        add_next   = '0;
        state_next = ST_WAIT_ACK;
`ifdef SCDAQ_RDO_TIMEOUT_EN
        // The REQ cycle counts as the first cycle Req is high
        tmo_cnt_next = TMO_W'(1);
`endif
      end
      ST_WAIT_ACK: begin
        if (ack_sel) begin
          cnt_next   = LAT_W'(RD_LAT);
          state_next = ST_FETCH;
        end
`ifdef SCDAQ_RDO_TIMEOUT_EN
        else if (tmo_cnt_reg >= TMO_W'(ACK_TIMEOUT - 1)) begin
          tmo_err_next = tmo_err_reg | ch_onehot;
          ptr_next     = ptr_reg + PTR_W'(1);
          state_next   = ST_SCAN;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
`endif
      end
      ST_FETCH: begin
        // RDO_Q for the current address is valid once the counter drains
        if (cnt_reg == '0) begin
          out_data_next  = mux_data;
          out_valid_next = 1'b1;
          out_ch_next    = ch_idx;
          out_last_next  = last_sample;
          state_next     = ST_PUSH;
        end else begin
          cnt_next = cnt_reg - LAT_W'(1);
        end
      end
      ST_PUSH: begin
        // OUT_Valid is always high here, so Ready alone completes the transfer
        if (OUT_Ready) begin
          out_valid_next = 1'b0;
          if (out_last_reg) begin
            state_next = ST_DONE;
          end else begin
            add_next   = add_reg + RDO_ADD_BLEN'(1);
            cnt_next   = LAT_W'(RD_LAT);
            state_next = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!ack_sel) begin
          ptr_next   = ptr_reg + PTR_W'(1);
          state_next = ST_SCAN;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any round
  always_ff @(posedge RDO_Clock) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      snap_reg      <= '0;
      ptr_reg       <= '0;
      add_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_last_reg  <= 1'b0;
`ifdef SCDAQ_RDO_TIMEOUT_EN
      tmo_cnt_reg   <= '0;
      tmo_err_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      snap_reg      <= snap_next;
      ptr_reg       <= ptr_next;
      add_reg       <= add_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_last_reg  <= out_last_next;
`ifdef SCDAQ_RDO_TIMEOUT_EN
      tmo_cnt_reg   <= tmo_cnt_next;
      tmo_err_reg   <= tmo_err_next;
`endif
    end
  end

endmodule

// File: tb/tb_scdaq_rdo_sched.sv
// Directed bench for scdaq_rdo_sched (NCH=4, 512 samples, RD_LAT=1).
// Buffers return (ch<<10)|addr with a one-cycle registered read; Ack is
// modelled per channel with configurable delay; a scoreboard tracks the
// expected word sequence. With SCDAQ_RDO_TIMEOUT_EN the timeout path is
// exercised with ACK_TIMEOUT=16.
module tb_scdaq_rdo_sched;

  localparam int NCH  = 4;
  localparam int PREC = 14;
  localparam int NS   = 512;
`ifdef SCDAQ_RDO_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 1024;
`endif

  logic            clk = 1'b0;
  logic            rst, start, ready;
  logic [3:0]      ch_en, ack;
  logic [55:0]     q;
  logic            Busy, Round_Done, OUT_Valid, OUT_Last;
  logic [3:0]      RDO_Req, RDO_Done, Timeout_Err;
  logic [8:0]      RDO_Add;
  logic [13:0]     OUT_Data;
  logic [1:0]      OUT_Ch;
  logic [63:0]     outvec;

  always #5 clk = ~clk;

  scdaq_rdo_sched #(
    .NCH(NCH), .CH_BLEN(2), .NSAMPLES(NS), .PRECISION(PREC),
    .RDO_ADD_BLEN(9), .RD_LAT(1), .ACK_TIMEOUT(TB_TMO)
  ) dut (
    .RDO_Clock(clk), .Reset(rst), .Start(start), .CH_EN(ch_en),
    .Busy(Busy), .Round_Done(Round_Done), .RDO_Req(RDO_Req), .RDO_Ack(ack),
    .RDO_Add(RDO_Add), .RDO_Q(q), .RDO_Done(RDO_Done), .OUT_Valid(OUT_Valid),
    .OUT_Ready(ready), .OUT_Data(OUT_Data), .OUT_Ch(OUT_Ch), .OUT_Last(OUT_Last),
    .Timeout_Err(Timeout_Err)
  );

  assign outvec = 64'({Busy, Round_Done, RDO_Req, RDO_Add, RDO_Done, OUT_Valid,
                       OUT_Data, OUT_Ch, OUT_Last, Timeout_Err});

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard / monitor state
  logic [3:0]  sb_mask, req_seen, done_seen, never_ack;
  int          exp_ch, exp_add, words, bad, lasts, done_cnt, rd_cnt, rd_cyc, rcyc;
  int          onehot_bad, stab_bad, gap_bad, req1_cyc, last_hs, prev_word_ch, ack_max;
  int          ack_cnt [4];
  int          ack_dly [4];
  bit          rd_hit, prev_stall, rnd_ready, mid_start, gap_chk, start_at_rd;
  logic [13:0] prev_data;
  logic [1:0]  prev_ch;
  logic        prev_last;
  logic [8:0]  add_prev;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_en(input int from);
    for (int i = from; i < 4; i++) if (sb_mask[i]) return i;
    return 4;
  endfunction

  task automatic sb_clear(input logic [3:0] m);
    sb_mask = m; exp_ch = next_en(0); exp_add = 0;
    words = 0; bad = 0; lasts = 0; done_cnt = 0; rd_cnt = 0; rd_cyc = 0; rd_hit = 0;
    req_seen = 0; done_seen = 0; onehot_bad = 0; stab_bad = 0; gap_bad = 0;
    req1_cyc = 0; last_hs = 0; prev_word_ch = -1; prev_stall = 0;
  endtask

  // One clock: observe DUT after the edge, update models, drive next inputs
  task automatic tick();
    logic [13:0] ed;
    @(posedge clk); #1;
    rcyc++;
    if (!$onehot0(RDO_Req) || !$onehot0(RDO_Done)) onehot_bad++;
    req_seen  |= RDO_Req;
    done_seen |= RDO_Done;
    if (|RDO_Done) done_cnt++;
    if (RDO_Req[1]) req1_cyc++;
    if (Round_Done) begin
      rd_cnt++;
      if (!rd_hit) rd_cyc = rcyc;
      rd_hit = 1;
    end
    if (prev_stall && (!OUT_Valid || OUT_Data !== prev_data || OUT_Ch !== prev_ch ||
                       OUT_Last !== prev_last)) stab_bad++;
    // Buffers: registered read of the address seen last cycle
    for (int k = 0; k < 4; k++) q[k*14 +: 14] = 14'((k << 10) | int'(add_prev));
    add_prev = RDO_Add;
    // Ack model
    for (int k = 0; k < 4; k++) begin
      if (RDO_Req[k]) begin
        if (!ack[k] && !never_ack[k]) begin
          if (ack_cnt[k] >= ack_dly[k]) ack[k] = 1'b1;
          else ack_cnt[k]++;
        end
      end else begin
        ack[k] = 1'b0;
        ack_cnt[k] = 0;
        ack_dly[k] = int'($urandom_range(0, ack_max));
      end
    end
    ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (OUT_Valid && ready) begin
      ed = 14'((exp_ch << 10) | exp_add);
      if (exp_ch > 3 || OUT_Data !== ed || OUT_Ch !== 2'(exp_ch) ||
          OUT_Last !== (exp_add == NS - 1)) bad++;
      if (OUT_Last) lasts++;
      if (gap_chk && words > 0 && prev_word_ch == exp_ch && (rcyc - last_hs) != 3) gap_bad++;
      prev_word_ch = exp_ch;
      last_hs = rcyc;
      words++;
      if (exp_add == NS - 1) begin
        exp_add = 0;
        exp_ch = next_en(exp_ch + 1);
      end else begin
        exp_add++;
      end
    end
    prev_stall = OUT_Valid && !ready;
    prev_data = OUT_Data; prev_ch = OUT_Ch; prev_last = OUT_Last;
    if (mid_start)
      start = (rcyc == 50 || rcyc == 900 || rcyc == 2000 || rcyc == 3500 || rcyc == 6000);
  endtask

  // Start a round with mask, run it to Round_Done (bounded), then a few idle cycles
  task automatic run_round(input string tag, input logic [3:0] mask, input int budget);
    sb_clear(mask & ~never_ack);
    ch_en = mask; start = 1'b1; rcyc = 1;
    tick();
    start = 1'b0;
    ch_en = ~mask;  // must not affect the round in progress
    while (!rd_hit && rcyc < budget) tick();
    check({tag, "_round_done"}, 64'(rd_hit), 64'(1));
    if (start_at_rd) start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    $display("[TB] round %s mask=%b: words=%0d cycles=%0d done=%b", tag, mask, words, rcyc, done_seen);
  endtask

  initial begin
    rst = 1; start = 0; ch_en = 0; ack = 0; q = 0; ready = 0; add_prev = 0;
    rnd_ready = 0; mid_start = 0; gap_chk = 0; start_at_rd = 0; never_ack = 0; ack_max = 0;
    for (int k = 0; k < 4; k++) begin ack_cnt[k] = 0; ack_dly[k] = 0; end
    sb_clear(4'b0000);
    repeat (3) tick();
    check("rst_outputs", outvec, 64'(0));
    rst = 0;
    tick();
    check("idle_busy", 64'(Busy), 64'(0));

    // Full round, Ready held high, immediate Ack
    gap_chk = 1;
    run_round("t1", 4'b1111, 20000);
    check("t1_words", 64'(words), 64'(2048));
    check("t1_bad", 64'(bad), 64'(0));
    check("t1_lasts", 64'(lasts), 64'(4));
    check("t1_done_mask", 64'(done_seen), 64'(4'b1111));
    check("t1_done_cnt", 64'(done_cnt), 64'(4));
    check("t1_rd_cnt", 64'(rd_cnt), 64'(1));
    check("t1_cadence", 64'(gap_bad), 64'(0));
    check("t1_onehot", 64'(onehot_bad), 64'(0));
    check("t1_tmo_err", 64'(Timeout_Err), 64'(0));
    gap_chk = 0;

    // Empty mask: Round_Done in the 6th cycle counting the Start cycle as 1
    run_round("t2", 4'b0000, 100);
    check("t2_rd_cycle", 64'(rd_cyc), 64'(6));
    check("t2_no_req", 64'(req_seen), 64'(0));
    check("t2_words", 64'(words), 64'(0));
    check("t2_rd_cnt", 64'(rd_cnt), 64'(1));

    // Sparse mask, random Ready and Ack delays
    rnd_ready = 1; ack_max = 20;
    run_round("t3", 4'b1010, 30000);
    check("t3_words", 64'(words), 64'(1024));
    check("t3_bad", 64'(bad), 64'(0));
    check("t3_stable", 64'(stab_bad), 64'(0));
    check("t3_req_mask", 64'(req_seen), 64'(4'b1010));
    check("t3_done_mask", 64'(done_seen), 64'(4'b1010));
    check("t3_onehot", 64'(onehot_bad), 64'(0));
    rnd_ready = 0; ack_max = 0;

    // Reset at sample 200 of ch2, then a fresh round
    begin
      bit found;
      found = 0;
      sb_clear(4'b1111);
      ch_en = 4'b1111; start = 1'b1; rcyc = 1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10000 && !found; i++) begin
        tick();
        if (OUT_Valid && OUT_Ch == 2'd2 && OUT_Data == 14'd2248) found = 1;
      end
      check("t4_reach", 64'(found), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_rst_outputs", outvec, 64'(0));
      sb_clear(4'b0000);
      repeat (20) tick();
      check("t4_post_words", 64'(words), 64'(0));
      check("t4_post_done", 64'(done_seen), 64'(0));
      check("t4_post_req", 64'(req_seen), 64'(0));
    end
    run_round("t4r", 4'b1111, 20000);
    check("t4r_words", 64'(words), 64'(2048));
    check("t4r_bad", 64'(bad), 64'(0));

    // Start pulses mid-round and on the Round_Done cycle are ignored
    mid_start = 1; start_at_rd = 1;
    run_round("t5", 4'b1111, 20000);
    mid_start = 0; start_at_rd = 0;
    check("t5_rd_cnt", 64'(rd_cnt), 64'(1));
    check("t5_words", 64'(words), 64'(2048));
    check("t5_bad", 64'(bad), 64'(0));
    check("t5_busy_after", 64'(Busy), 64'(0));

`ifdef SCDAQ_RDO_TIMEOUT_EN
    // ch1 never acknowledges
    never_ack = 4'b0010;
    run_round("t6", 4'b1111, 20000);
    check("t6_req1_cycles", 64'(req1_cyc), 64'(16));
    check("t6_tmo_err", 64'(Timeout_Err), 64'(4'b0010));
    check("t6_words", 64'(words), 64'(1536));
    check("t6_bad", 64'(bad), 64'(0));
    check("t6_done_mask", 64'(done_seen), 64'(4'b1101));
    never_ack = 4'b0000;
    run_round("t6b", 4'b0000, 100);
    check("t6b_tmo_clear", 64'(Timeout_Err), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scdaq_rdo_sched.md
Name: scdaq_rdo_sched

Overview:
Readout scheduler for a bank of NCH single-channel DAQ buffers sharing one readout clock domain. On a Start pulse it visits each enabled channel in ascending index order. For each channel it performs the Req/Ack/Done handshake, sweeps the readout address 0..NSAMPLES-1 and forwards every sample as a tagged word on a valid/ready output stream. It sits between the per-channel buffers and the host transfer path (FIFO/serialiser).

Parameters:
NCH, 4, number of DAQ channels served
CH_BLEN, 2, channel index width (ceil(log2(NCH)), min 1)
NSAMPLES, 512, samples read per channel
PRECISION, 14, sample width
RDO_ADD_BLEN, 9, readout address width
RD_LAT, 1, RDO_Clock cycles from a RDO_Add change to valid RDO_Q (1..3)
ACK_TIMEOUT, 1024, Ack wait limit in cycles (used only with the optional feature)

Ports:
RDO_Clock  in  1  readout clock; the only clock
Reset  in  1  synchronous, active-high reset
Start  in  1  single-cycle pulse that begins a readout round
CH_EN  in  NCH  channel enable mask, sampled on an accepted Start
Busy  out  1  round in progress
Round_Done  out  1  1-cycle pulse at end of round
RDO_Req  out  NCH  per-channel readout request
RDO_Ack  in  NCH  per-channel acknowledgement
RDO_Add  out  RDO_ADD_BLEN  shared readout address
RDO_Q  in  NCH*PRECISION  concatenated channel data; ch k at [k*PRECISION +: PRECISION]
RDO_Done  out  NCH  per-channel 1-cycle done pulse
OUT_Valid  out  1  stream word valid
OUT_Ready  in  1  stream sink ready
OUT_Data  out  PRECISION  sample value
OUT_Ch  out  CH_BLEN  source channel of sample
OUT_Last  out  1  marks last sample of a channel
Timeout_Err  out  NCH  sticky per-channel Ack timeout flags (only with the optional feature)

Behaviour:
- Reset (sampled on the RDO_Clock edge) sets every output to 0 and the FSM to IDLE. The mask snapshot, channel pointer, address and wait counter are also cleared. Reset mid-round abandons the round: Req drops with no Done pulse and no further stream words are issued.
- FSM states:
  - IDLE: Busy=0. On Start, latch CH_EN into the snapshot, set ptr=0, go to SCAN. Start is ignored while Busy=1.
  - SCAN: if ptr>=NCH, pulse Round_Done for one cycle and go to IDLE. Else if snapshot[ptr]=0, increment ptr and stay in SCAN. Else go to REQ. Cost is 1 cycle per skipped channel.
  - REQ: RDO_Req[ptr]=1 and RDO_Add=0. Go to WAIT_ACK.
  - WAIT_ACK: hold Req. When RDO_Ack[ptr]=1, load the wait counter with RD_LAT and go to FETCH.
  - FETCH: count the wait counter down. When it reaches 0, capture RDO_Q slice ptr into OUT_Data and set OUT_Valid=1, OUT_Ch=ptr, OUT_Last=(Add==NSAMPLES-1). Go to PUSH.
  - PUSH: hold OUT_* stable while OUT_Ready=0.
    - On Valid&Ready with Last=0: OUT_Valid drops the next cycle, Add increments, the counter reloads, go to FETCH.
    - On Valid&Ready with Last=1: go to DONE.
  - DONE: RDO_Req[ptr]=0 and RDO_Done[ptr]=1 for exactly one cycle. Go to RELEASE.
  - RELEASE: wait for RDO_Ack[ptr]=0, then increment ptr and go to SCAN.
- Req and Done are one-hot or zero. Only RDO_Q slice ptr is observed.
- Throughput per sample is RD_LAT+2 cycles when OUT_Ready is held high.
- RDO_Add never exceeds NSAMPLES-1 and resets to 0 in REQ.
- An Ack arriving in the same cycle as Req assertion is not sampled until WAIT_ACK.
- Ack deasserting during FETCH/PUSH is ignored; the sweep completes.
- CH_EN changes during a round have no effect.
- A Start pulse coincident with the Round_Done cycle is ignored.

Optional Feature:
SCDAQ_RDO_TIMEOUT_EN.
- Defined: WAIT_ACK counts cycles. At ACK_TIMEOUT cycles without Ack, drop Req, set Timeout_Err[ptr] (sticky until Reset or the next accepted Start), issue no Done and no samples, and go to SCAN with ptr+1.
- Undefined: WAIT_ACK waits indefinitely and Timeout_Err is tied to 0.

Decomposition:
- Package scdaq_pkg holds:
  - state encoding constants (IDLE, SCAN, REQ, WAIT_ACK, FETCH, PUSH, DONE, RELEASE)
  - default PRECISION/NSAMPLES/RDO_ADD_BLEN constants
  - timeout counter width derivation
- Sub-module scdaq_rdo_mux: combinational NCH-to-1 slice select of RDO_Q by ptr. The capture register lives in the parent.

Test Plan:
- NCH=4, CH_EN=4'b1111, Ready held 1, buffers return data=(ch<<10)|addr. Expect 2048 words in order ch0..3, addr 0..511; OUT_Last on addr 511 only; 4 Done pulses; one Round_Done; 3 cycles per sample.
- CH_EN=4'b0000, Start. Expect Round_Done 6 cycles after Start (1 IDLE-to-SCAN cycle + 4 skips + 1 terminal SCAN cycle), no Req, no words.
- CH_EN=4'b1010 with random Ready (50%) and Ack delays of 0..20 cycles. Expect only ch1 then ch3 served; OUT_* stable while Valid&~Ready; no word lost or duplicated.
- Assert Reset at sample 200 of ch2. Expect all outputs 0 the next cycle, no Done[2], and a fresh Start restarting at ch0 addr 0.
- Start pulses at 5 random points mid-round. Expect no effect and a single Round_Done.
- With SCDAQ_RDO_TIMEOUT_EN and ACK_TIMEOUT=16, ch1 never Acks. Expect Req[1] high for 16 cycles, then Timeout_Err=4'b0010; ch0, ch2 and ch3 fully read out.
